// File: rtl/toggle_event_receiver.sv
// Receive endpoint of the toggle event link: synchronizes t_in, decodes level changes into
// valid/ready events, and returns an acknowledge toggle. TOGGLE_RX_COUNT_EN adds ev_count.
module toggle_event_receiver #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_WIDTH   = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic t_in,
  output logic ev_valid,
  input  logic ev_ready,
  output logic ack_t,
  output logic overrun,
  input  logic clear_overrun
`ifdef TOGGLE_RX_COUNT_EN
  ,
  output logic [CNT_WIDTH-1:0] ev_count
`endif
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
    $error("toggle_event_receiver: SYNC_STAGES must be in 2..4");
  end
  if (CNT_WIDTH < 1) begin : g_bad_cnt_width
    $error("toggle_event_receiver: CNT_WIDTH must be at least 1");
  end

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   prev;
  logic                   det;

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign det      = sync_out ^ prev;

  // Synchronizer chain and edge-detect history
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      prev   <= sync_out;
    end
  end

  // Event FSM; a new event arriving on the accepting cycle replaces the accepted one
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      ev_valid <= 1'b0;
      ack_t    <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (clear_overrun) overrun <= 1'b0;
      case (state)
        IDLE: begin
          if (det) begin
            state    <= PENDING;
            ev_valid <= 1'b1;
          end
        end
        PENDING: begin
          if (ev_ready) begin
            ack_t <= ~ack_t;
            if (!det) begin
              state    <= IDLE;
              ev_valid <= 1'b0;
            end
          end else if (det) begin
            overrun <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef TOGGLE_RX_COUNT_EN
  // Accepted-event counter, wraps silently
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ev_count <= '0;
    end else if (ev_valid && ev_ready) begin
      ev_count <= ev_count + CNT_WIDTH'(1);
    end
  end
`endif

endmodule
